// File: rtl/sum_accumulator_if.sv
// Frame control, beat input and result output bundle for sum_accumulator.
// The controller/adder side uses the master modport, the accumulator the slave.
interface sum_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
);
  // Frame control
  logic              start;
  logic              clr;
  logic [CNT_W-1:0]  len;
  logic              busy;
  // Upstream beat handshake (adder sum plus carry)
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_carry;
  // Downstream result handshake
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W:0]    out_count;
  logic              out_ovf;

  modport master (
    output start, clr, len, in_valid, in_data, in_carry, out_ready,
    input  busy, in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  start, clr, len, in_valid, in_data, in_carry, out_ready,
    output busy, in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/sum_accumulator.sv
// Saturating frame accumulator for the adder's {carry, sum} beats.
// IDLE waits for start, ACCUM collects len beats, HOLD presents the result
// until the downstream consumer takes it.
module sum_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input logic               clk,
  input logic               rst,
  sum_accumulator_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
  logic             ovf_q,   ovf_d;
  logic [CNT_W:0]   cnt_q,   cnt_d;
  logic [CNT_W:0]   len_q,   len_d;

  logic [ACC_W:0]   beat_ext;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W:0]   len_ext;
  logic             beat_fire;

  // Beat is {carry, sum}; one spare bit on the adder exposes overflow.
  assign beat_ext  = {{(ACC_W-DATA_W){1'b0}}, bus.in_carry, bus.in_data};
  assign sum_ext   = {1'b0, acc_q} + beat_ext;
  // A length of zero stands for a full 2^CNT_W-beat frame.
  assign len_ext   = (bus.len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, bus.len};
  assign beat_fire = (state_q == S_ACCUM) && bus.in_valid;

  // Next-state and datapath decisions; clr overrides normal operation.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (bus.clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = S_ACCUM;
            len_d   = len_ext;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        S_ACCUM: begin
          if (beat_fire) begin
            if (sum_ext[ACC_W]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum_ext[ACC_W-1:0];
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == len_q) state_d = S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Handshake outputs are pure state decodes; result outputs are the registers.
  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_HOLD);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

endmodule
